// File: rtl/sfft_frame_capture_ctrl_if.sv
// Bundle between the SFFT frame capture controller, the SFFT output mux, the
// ping-pong readout RAM and the host bus. decim exists only with SFFT_CAPTURE_DECIMATE_EN.
interface sfft_frame_capture_ctrl_if #(
  parameter int ADDR_WIDTH    = 7,
  parameter int BIN_WIDTH     = 32,
  parameter int COUNTER_WIDTH = 32,
  parameter int DROP_WIDTH    = 16
);
  logic                     frame_valid;
  logic [ADDR_WIDTH-1:0]    bin_idx;
  logic [BIN_WIDTH-1:0]     bin_data;
  logic                     wr_en;
  logic                     wr_bank;
  logic [ADDR_WIDTH-1:0]    wr_addr;
  logic [BIN_WIDTH-1:0]     wr_data;
  logic                     host_busy;
  logic                     rd_bank;
  logic [COUNTER_WIDTH-1:0] frame_count;
  logic [DROP_WIDTH-1:0]    dropped_count;
  logic                     capture_busy;
`ifdef SFFT_CAPTURE_DECIMATE_EN
  logic [3:0]               decim;
`endif

  // The capture controller drives the RAM write port and the published status.
  modport master (
`ifdef SFFT_CAPTURE_DECIMATE_EN
    input  decim,
`endif
    input  frame_valid, bin_data, host_busy,
    output bin_idx, wr_en, wr_bank, wr_addr, wr_data,
    output rd_bank, frame_count, dropped_count, capture_busy
  );

  modport slave (
`ifdef SFFT_CAPTURE_DECIMATE_EN
    output decim,
`endif
    output frame_valid, bin_data, host_busy,
    input  bin_idx, wr_en, wr_bank, wr_addr, wr_data,
    input  rd_bank, frame_count, dropped_count, capture_busy
  );
endinterface

// File: rtl/sfft_frame_capture_ctrl.sv
// Copies one completed SFFT frame into a ping-pong RAM, one bin per cycle, and swaps
// banks only between host reads. Optional SFFT_CAPTURE_DECIMATE_EN captures every (decim+1)th frame.
module sfft_frame_capture_ctrl #(
  parameter int NFFT          = 128,
  parameter int ADDR_WIDTH    = 7,
  parameter int BIN_WIDTH     = 32,
  parameter int COUNTER_WIDTH = 32,
  parameter int DROP_WIDTH    = 16
) (
  input logic                       clk,
  input logic                       reset,
  sfft_frame_capture_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COPY      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] LAST_BIN = ADDR_WIDTH'(NFFT - 1);

  state_e                   state_q;
  logic                     fv_q;
  logic [ADDR_WIDTH-1:0]    bin_idx_q;
  logic                     wr_en_q;
  logic                     wr_bank_q;
  logic [ADDR_WIDTH-1:0]    wr_addr_q;
  logic [BIN_WIDTH-1:0]     wr_data_q;
  logic                     rd_bank_q;
  logic [COUNTER_WIDTH-1:0] frame_count_q;
  logic [DROP_WIDTH-1:0]    dropped_count_q;

  logic frame_edge;
  logic start_capture;

  assign frame_edge = bus.frame_valid & ~fv_q;

`ifdef SFFT_CAPTURE_DECIMATE_EN
  logic [3:0] skip_q;

  // >= rather than == so a decim lowered mid-count cannot strand the counter.
  assign start_capture = frame_edge && (skip_q >= bus.decim);

  always_ff @(posedge clk) begin
    if (reset) begin
      skip_q <= 4'd0;
    end else if (state_q == IDLE && frame_edge) begin
      skip_q <= start_capture ? 4'd0 : skip_q + 4'd1;
    end
  end
`else
  assign start_capture = frame_edge;
`endif

  // NOTE: all state here is written with <= so every register samples the
  // pre-edge values; blocking assignments would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      fv_q            <= 1'b0;
      bin_idx_q       <= '0;
      wr_en_q         <= 1'b0;
      wr_bank_q       <= 1'b0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      rd_bank_q       <= 1'b0;
      frame_count_q   <= '0;
      dropped_count_q <= '0;
    end else begin
      fv_q    <= bus.frame_valid;
      wr_en_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start_capture) begin
            state_q   <= COPY;
            bin_idx_q <= '0;
            wr_bank_q <= ~rd_bank_q;
          end
        end
        COPY: begin
          // Write is registered, so each bin lands one cycle after its index is presented.
          wr_en_q   <= 1'b1;
          wr_addr_q <= bin_idx_q;
          wr_data_q <= bus.bin_data;
          if (bin_idx_q == LAST_BIN) begin
            state_q <= WAIT_SWAP;
          end else begin
            bin_idx_q <= bin_idx_q + ADDR_WIDTH'(1);
          end
        end
        WAIT_SWAP: begin
          if (!bus.host_busy) begin
            rd_bank_q     <= ~rd_bank_q;
            frame_count_q <= frame_count_q + COUNTER_WIDTH'(1);
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      // Any edge outside IDLE, including the swap cycle itself, is lost; count saturates.
      if (frame_edge && state_q != IDLE && dropped_count_q != '1) begin
        dropped_count_q <= dropped_count_q + DROP_WIDTH'(1);
      end
    end
  end

  assign bus.bin_idx       = bin_idx_q;
  assign bus.wr_en         = wr_en_q;
  assign bus.wr_bank       = wr_bank_q;
  assign bus.wr_addr       = wr_addr_q;
  assign bus.wr_data       = wr_data_q;
  assign bus.rd_bank       = rd_bank_q;
  assign bus.frame_count   = frame_count_q;
  assign bus.dropped_count = dropped_count_q;
  assign bus.capture_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_sfft_frame_capture_ctrl.sv
// Directed bench for sfft_frame_capture_ctrl with NFFT=8 and a 4-bit frame counter.
// Define SFFT_CAPTURE_DECIMATE_EN to also exercise the decimation scenario.
module tb_sfft_frame_capture_ctrl;
  localparam int NFFT = 8;
  localparam int AW   = 3;
  localparam int BW   = 32;
  localparam int CW   = 4;
  localparam int DW   = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  sfft_frame_capture_ctrl_if #(
    .ADDR_WIDTH(AW), .BIN_WIDTH(BW), .COUNTER_WIDTH(CW), .DROP_WIDTH(DW)
  ) bus ();

  sfft_frame_capture_ctrl #(
    .NFFT(NFFT), .ADDR_WIDTH(AW), .BIN_WIDTH(BW), .COUNTER_WIDTH(CW), .DROP_WIDTH(DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Model of the external SFFT_Out mux: bin n carries 0x100 + n.
  always_comb bus.bin_data = 32'h100 + 32'(bus.bin_idx);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    bus.frame_valid = 1'b0;
    bus.host_busy   = 1'b0;
`ifdef SFFT_CAPTURE_DECIMATE_EN
    bus.decim       = 4'd0;
`endif
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Returns just after the edge that samples the rising frame_valid.
  task automatic pulse_frame();
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.bin_idx, bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data, bus.rd_bank,
         bus.frame_count, bus.dropped_count, bus.capture_busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got bin_idx=%0d wr_en=%b wr_addr=%0d wr_data=%h rd_bank=%b fc=%0d dc=%0d busy=%b want all 0",
               bus.bin_idx, bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_bank,
               bus.frame_count, bus.dropped_count, bus.capture_busy);
    end
  endtask

  task automatic test_single_frame();
    logic        exp_en;
    logic [31:0] exp_data;
    do_reset();
    tick();
    tick();
    pulse_frame();
    checks++;
    if ({bus.capture_busy, bus.bin_idx, bus.wr_bank, bus.wr_en} !== {1'b1, 3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL single_start: got busy=%b bin_idx=%0d wr_bank=%b wr_en=%b want 1 0 1 0",
               bus.capture_busy, bus.bin_idx, bus.wr_bank, bus.wr_en);
    end
    for (int i = 1; i <= 9; i++) begin
      tick();
      exp_en = (i <= 8);
      checks++;
      if (bus.wr_en !== exp_en) begin
        errors++;
        $display("FAIL single_wr_en[%0d]: got %b want %b", i, bus.wr_en, exp_en);
      end
      if (exp_en) begin
        exp_data = 32'h100 + 32'(i - 1);
        checks++;
        if (bus.wr_addr !== 3'(i - 1) || bus.wr_data !== exp_data || bus.wr_bank !== 1'b1) begin
          errors++;
          $display("FAIL single_write[%0d]: got addr=%0d data=%h bank=%b want addr=%0d data=%h bank=1",
                   i, bus.wr_addr, bus.wr_data, bus.wr_bank, i - 1, exp_data);
        end
      end
      checks++;
      if (bus.rd_bank !== (i >= 9)) begin
        errors++;
        $display("FAIL single_rd_bank[%0d]: got %b want %b", i, bus.rd_bank, (i >= 9));
      end
    end
    checks++;
    if ({bus.frame_count, bus.dropped_count, bus.capture_busy} !== {4'd1, 16'd0, 1'b0}) begin
      errors++;
      $display("FAIL single_final: got fc=%0d dc=%0d busy=%b want 1 0 0",
               bus.frame_count, bus.dropped_count, bus.capture_busy);
    end
    checks++;
    if (bus.wr_addr !== 3'd7 || bus.wr_data !== 32'h107) begin
      errors++;
      $display("FAIL single_hold: got addr=%0d data=%h want 7 107", bus.wr_addr, bus.wr_data);
    end
  endtask

  task automatic test_host_busy();
    int writes;
    writes = 0;
    do_reset();
    pulse_frame();
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (i == 3) bus.host_busy = 1'b1;
      if (bus.wr_en === 1'b1) writes++;
    end
    checks++;
    if (writes != 8) begin
      errors++;
      $display("FAIL busy_writes: got %0d want 8", writes);
    end
    checks++;
    if ({bus.rd_bank, bus.frame_count, bus.capture_busy} !== {1'b0, 4'd0, 1'b1}) begin
      errors++;
      $display("FAIL busy_held: got rd_bank=%b fc=%0d busy=%b want 0 0 1",
               bus.rd_bank, bus.frame_count, bus.capture_busy);
    end
    bus.host_busy = 1'b0;
    tick();
    checks++;
    if ({bus.rd_bank, bus.frame_count, bus.capture_busy} !== {1'b1, 4'd1, 1'b0}) begin
      errors++;
      $display("FAIL busy_release: got rd_bank=%b fc=%0d busy=%b want 1 1 0",
               bus.rd_bank, bus.frame_count, bus.capture_busy);
    end
  endtask

  task automatic test_drop_in_copy();
    int writes;
    writes = 0;
    do_reset();
    pulse_frame();
    for (int i = 1; i <= 20; i++) begin
      bus.frame_valid = (i == 3);
      tick();
      if (bus.wr_en === 1'b1) writes++;
      if (i == 3) begin
        checks++;
        if (bus.dropped_count !== 16'd1) begin
          errors++;
          $display("FAIL drop_copy_count: got %0d want 1", bus.dropped_count);
        end
      end
    end
    checks++;
    if (writes != 8 || bus.frame_count !== 4'd1 || bus.dropped_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_copy_final: got writes=%0d fc=%0d dc=%0d want 8 1 1",
               writes, bus.frame_count, bus.dropped_count);
    end
  endtask

  task automatic test_drop_at_swap();
    do_reset();
    pulse_frame();
    repeat (8) tick();
    bus.frame_valid = 1'b1;
    tick();
    checks++;
    if ({bus.frame_count, bus.dropped_count, bus.capture_busy} !== {4'd1, 16'd1, 1'b0}) begin
      errors++;
      $display("FAIL drop_swap: got fc=%0d dc=%0d busy=%b want 1 1 0",
               bus.frame_count, bus.dropped_count, bus.capture_busy);
    end
    repeat (5) tick();
    checks++;
    if (bus.capture_busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_swap_level: got busy=%b want 0", bus.capture_busy);
    end
    bus.frame_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_copy();
    int writes;
    writes = 0;
    do_reset();
    pulse_frame();
    repeat (4) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.bin_idx, bus.wr_en, bus.wr_bank, bus.wr_addr, bus.wr_data, bus.rd_bank,
         bus.frame_count, bus.dropped_count, bus.capture_busy} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got bin_idx=%0d wr_en=%b wr_addr=%0d wr_data=%h rd_bank=%b busy=%b want all 0",
               bus.bin_idx, bus.wr_en, bus.wr_addr, bus.wr_data, bus.rd_bank, bus.capture_busy);
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.wr_en === 1'b1) writes++;
    end
    checks++;
    if (writes != 0 || bus.rd_bank !== 1'b0 || bus.frame_count !== 4'd0) begin
      errors++;
      $display("FAIL midreset_quiet: got writes=%0d rd_bank=%b fc=%0d want 0 0 0",
               writes, bus.rd_bank, bus.frame_count);
    end
    pulse_frame();
    tick();
    checks++;
    if ({bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_bank} !== {1'b1, 3'd0, 32'h100, 1'b1}) begin
      errors++;
      $display("FAIL midreset_restart: got en=%b addr=%0d data=%h bank=%b want 1 0 100 1",
               bus.wr_en, bus.wr_addr, bus.wr_data, bus.wr_bank);
    end
    repeat (10) tick();
    checks++;
    if (bus.frame_count !== 4'd1 || bus.rd_bank !== 1'b1) begin
      errors++;
      $display("FAIL midreset_complete: got fc=%0d rd_bank=%b want 1 1", bus.frame_count, bus.rd_bank);
    end
  endtask

  task automatic test_counter_wrap();
    logic [3:0] exp_fc;
    do_reset();
    for (int n = 0; n < 16; n++) begin
      pulse_frame();
      checks++;
      if (bus.wr_bank !== ~1'(n)) begin
        errors++;
        $display("FAIL wrap_wr_bank[%0d]: got %b want %b", n, bus.wr_bank, ~1'(n));
      end
      repeat (10) tick();
      exp_fc = 4'(n + 1);
      checks++;
      if (bus.frame_count !== exp_fc || bus.rd_bank !== exp_fc[0]) begin
        errors++;
        $display("FAIL wrap_frame[%0d]: got fc=%0d rd_bank=%b want %0d %b",
                 n, bus.frame_count, bus.rd_bank, exp_fc, exp_fc[0]);
      end
    end
    checks++;
    if (bus.frame_count !== 4'd0 || bus.rd_bank !== 1'b0 || bus.dropped_count !== 16'd0) begin
      errors++;
      $display("FAIL wrap_final: got fc=%0d rd_bank=%b dc=%0d want 0 0 0",
               bus.frame_count, bus.rd_bank, bus.dropped_count);
    end
  endtask

`ifdef SFFT_CAPTURE_DECIMATE_EN
  task automatic test_decimate();
    do_reset();
    bus.decim = 4'd2;
    for (int k = 1; k <= 9; k++) begin
      pulse_frame();
      checks++;
      if (bus.capture_busy !== (k % 3 == 0)) begin
        errors++;
        $display("FAIL decim_edge[%0d]: got busy=%b want %b", k, bus.capture_busy, (k % 3 == 0));
      end
      repeat (10) tick();
    end
    checks++;
    if (bus.frame_count !== 4'd3 || bus.dropped_count !== 16'd0) begin
      errors++;
      $display("FAIL decim_final: got fc=%0d dc=%0d want 3 0", bus.frame_count, bus.dropped_count);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame();
    test_host_busy();
    test_drop_in_copy();
    test_drop_at_swap();
    test_reset_mid_copy();
    test_counter_wrap();
`ifdef SFFT_CAPTURE_DECIMATE_EN
    test_decimate();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfft_frame_capture_ctrl.md
Name: sfft_frame_capture_ctrl

Overview:
- Sequences the copy of one completed SFFT frame (NFFT amplitude bins) into a ping-pong readout RAM, one bin per cycle.
- Swaps banks so the host bus interface always reads a complete, coherent frame. The swap never happens while the host is mid-read (chipselect asserted).
- Maintains the frame timestamp counter and a dropped-frame counter.
- Sits between SFFT_Pipeline outputs and the host-readable buffer.

Parameters:
- NFFT, 128, number of bins per frame (power of two, ≥4)
- ADDR_WIDTH, 7, log2(NFFT)
- BIN_WIDTH, 32, width of one bin amplitude
- COUNTER_WIDTH, 32, width of frame_count
- DROP_WIDTH, 16, width of dropped_count

Ports:
- clk  in  1  system clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- frame_valid  in  1  SFFT OutputValid level; a rising edge marks a new frame
- bin_idx  out  ADDR_WIDTH  bin select driven to the external SFFT_Out mux
- bin_data  in  BIN_WIDTH  mux output, combinational from bin_idx
- wr_en  out  1  RAM write strobe
- wr_bank  out  1  RAM bank being written
- wr_addr  out  ADDR_WIDTH  RAM word address
- wr_data  out  BIN_WIDTH  RAM write data
- host_busy  in  1  host read in progress (chipselect)
- rd_bank  out  1  bank the host reads
- frame_count  out  COUNTER_WIDTH  number of frames published
- dropped_count  out  DROP_WIDTH  number of frame edges not captured
- capture_busy  out  1  high whenever state ≠ IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; fv_q (registered frame_valid) 0. Reset mid-copy abandons the partial frame; no swap occurs.
- Edge detect: edge = frame_valid & ~fv_q. fv_q updates every cycle.
- States:
  - IDLE
    - On edge: go to COPY; bin_idx←0; wr_bank←~rd_bank.
  - COPY
    - bin_idx increments each cycle from 0 to NFFT-1.
    - Write pipeline registers update every COPY cycle: wr_en←1, wr_addr←bin_idx, wr_data←bin_data. The write therefore lands one cycle after its index is presented.
    - On bin_idx==NFFT-1: go to WAIT_SWAP.
  - WAIT_SWAP
    - wr_en←0, so the final write, issued on the entry cycle, completes here.
    - If host_busy==0: rd_bank←~rd_bank; frame_count←frame_count+1 (wraps at 2^COUNTER_WIDTH); go to IDLE.
    - Else hold in WAIT_SWAP indefinitely.
- Timing for an edge sampled at cycle t:
  - COPY occupies t+1..t+NFFT.
  - wr_en is high at t+2..t+NFFT+1.
  - Earliest rd_bank toggle is visible at t+NFFT+2.
- Outside COPY, wr_en is 0. wr_addr and wr_data hold their last values.
- Drops:
  - An edge in COPY or WAIT_SWAP is not captured; dropped_count increments, saturating at all-ones.
  - An edge on the same cycle as the WAIT_SWAP→IDLE transition is also dropped.
  - No queueing of frames.
- host_busy asserting during COPY has no effect; only the swap is gated.
- rd_bank and frame_count change on the same clock edge, so the host sees a consistent pair between reads.

Optional Feature:
- Macro: SFFT_CAPTURE_DECIMATE_EN
- When defined:
  - Adds input port decim (4 bits).
  - An internal 4-bit skip counter counts edges seen in IDLE.
  - Only every (decim+1)th such edge starts a capture; the counter resets to 0 on a capture.
  - Skipped edges do not increment dropped_count.
  - decim is sampled only in IDLE.
  - decim=0 behaves identically to the undefined build.
  - The skip counter resets to 0.
- When undefined: no decim port; every IDLE edge is captured.

Test Plan:
- Reset, then a single frame_valid pulse at cycle 10 (NFFT=8, bin_data=0x100+bin_idx, host_busy=0) → wr_en high cycles 12–19, wr_addr 0..7, wr_data 0x100..0x107, wr_bank=1, rd_bank 0→1 at cycle 20, frame_count=1.
- host_busy held high from cycle 15 to 40 during the above → all 8 writes complete; rd_bank stays 0 until host_busy falls at 40; toggles at 41; frame_count=1 at 41.
- Second edge at cycle 14 while in COPY → dropped_count=1; only one frame written; frame_count=1.
- Reset asserted at cycle 15 mid-copy → all outputs 0 at 16; rd_bank=0; no further wr_en; a new edge at 20 restarts from bin 0.
- 2^COUNTER_WIDTH frames (COUNTER_WIDTH=4): 16 frames → frame_count wraps to 0; rd_bank toggles each frame, ending at 0.
- SFFT_CAPTURE_DECIMATE_EN with decim=2: 9 spaced edges → 3 captures (edges 3, 6, 9); frame_count=3; dropped_count=0.
